// File: rtl/ram_ctrl.sv
// Word-organised storage bank with a request/response handshake.
// Array words change only in the WRITE state; read data is held until taken.
module ram_ctrl #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_was_wr,
   output logic [7:0]        op_count
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                was_wr_q, was_wr_d;
   logic [7:0]          count_q, count_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [Depth-1:0]    word_en;
   logic [DATA_W-1:0]   mem_q [Depth];
   logic [DATA_W-1:0]   mem_d [Depth];

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      was_wr_d = was_wr_q;
      count_d  = count_q;
      word_en  = '0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = req_we ? StWrite : StRead;
            end
         end
         StWrite: begin
            word_en[addr_q] = 1'b1;
            rdata_d         = wdata_q;
            was_wr_d        = 1'b1;
            state_d         = StResp;
         end
         StRead: begin
            rdata_d  = mem_q[addr_q];
            was_wr_d = 1'b0;
            state_d  = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
               count_d = count_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Handshake outputs are registered from the next state, so no input reaches an output.
      req_ready_d = (state_d == StIdle);
      rsp_valid_d = (state_d == StResp);

      for (int unsigned i = 0; i < Depth; i++) begin
         mem_d[i] = word_en[i] ? wdata_q : mem_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         was_wr_q    <= 1'b0;
         count_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         was_wr_q    <= was_wr_d;
         count_q     <= count_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         mem_q       <= mem_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_was_wr = was_wr_q;
   assign op_count   = count_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: reset, write/read, isolation, backpressure,
// reset during a write, and op_count wrap with accept spacing.
module tb_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_was_wr;
   logic [7:0] op_count;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         acc_cyc = 0;
   logic [7:0] exp_cnt = 8'd0;

   ram_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_was_wr (rsp_was_wr),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with rsp_ready high; checks handshake timing along the way.
   task automatic do_op(input logic we, input logic [2:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic wr);
      int n = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      tick();
      acc_cyc   = cyc;
      req_valid = 1'b0;
      chk("rsp_valid_low_in_exec", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rsp_valid_one_after_accept", {31'd0, rsp_valid}, 32'd1);
      rd = rsp_rdata;
      wr = rsp_was_wr;
      tick();
      chk("rsp_consumed", {31'd0, rsp_valid}, 32'd0);
      exp_cnt++;
   endtask

   initial begin
      logic [7:0] rd;
      logic       wr;
      int         prev_acc;
      int         bad_space;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
      chk("reset_rsp_was_wr", {31'd0, rsp_was_wr}, 32'd0);
      chk("reset_op_count", {24'd0, op_count}, 32'd0);

      for (int k = 0; k < 8; k++) begin
         do_op(1'b0, 3'(k), 8'h00, rd, wr);
         chk("reset_read_data", {24'd0, rd}, 32'h00);
         chk("reset_read_was_wr", {31'd0, wr}, 32'd0);
      end
      chk("op_count_after_8", {24'd0, op_count}, 32'd8);

      do_op(1'b1, 3'd3, 8'hA5, rd, wr);
      chk("wr3_echo", {24'd0, rd}, 32'hA5);
      chk("wr3_was_wr", {31'd0, wr}, 32'd1);
      do_op(1'b0, 3'd3, 8'h00, rd, wr);
      chk("rd3_data", {24'd0, rd}, 32'hA5);
      chk("rd3_was_wr", {31'd0, wr}, 32'd0);

      for (int k = 0; k < 8; k++) begin
         do_op(1'b1, 3'(k), 8'h10 + 8'(k), rd, wr);
      end
      for (int k = 0; k < 8; k++) begin
         do_op(1'b0, 3'(k), 8'h00, rd, wr);
         chk("isolation_read", {24'd0, rd}, 32'h10 + 32'(k));
      end
      chk("op_count_running", {24'd0, op_count}, {24'd0, exp_cnt});

      // Backpressure: stall a read of addr 5 while a write request is presented.
      do_op(1'b1, 3'd5, 8'h3C, rd, wr);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 3'd5;
      tick();
      req_valid = 1'b0;
      tick();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_wdata = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_rsp_rdata", {24'd0, rsp_rdata}, 32'h3C);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("stall_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("stall_release_req_ready", {31'd0, req_ready}, 32'd1);
      do_op(1'b0, 3'd5, 8'h00, rd, wr);
      chk("addr5_unchanged", {24'd0, rd}, 32'h3C);
      chk("op_count_after_stall", {24'd0, op_count}, {24'd0, exp_cnt});

      // Reset asserted during the WRITE cycle.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 3'd2;
      req_wdata = 8'h77;
      tick();
      req_valid = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n   = 1'b1;
      exp_cnt = 8'd0;
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_op_count", {24'd0, op_count}, 32'd0);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      do_op(1'b0, 3'd2, 8'h00, rd, wr);
      chk("midrst_addr2", {24'd0, rd}, 32'h00);
      do_op(1'b0, 3'd5, 8'h00, rd, wr);
      chk("midrst_addr5_cleared", {24'd0, rd}, 32'h00);

      // Counter wrap over 256 back-to-back reads from a fresh reset.
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      exp_cnt = 8'd0;
      bad_space = 0;
      prev_acc  = 0;
      for (int i = 0; i < 256; i++) begin
         do_op(1'b0, 3'(i), 8'h00, rd, wr);
         if (i > 0 && acc_cyc - prev_acc != 3) bad_space++;
         prev_acc = acc_cyc;
         if (i == 254) chk("op_count_255", {24'd0, op_count}, 32'd255);
      end
      chk("accept_spacing_errors", 32'(bad_space), 32'd0);
      chk("op_count_wrap", {24'd0, op_count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Word-organised storage bank with a request/response handshake: it accepts read and write requests, drives a per-word write enable into its storage array, and returns read data through a held response register. It sits directly upstream of the latch-based bit cells of the RAM. It owns the array, the word enable and the sequencing, so that cell inputs change only during a defined write cycle and read data stays stable until the consumer takes it.

## Interface
- ADDR_W, default 3: address width; the array holds 2^ADDR_W words.
- DATA_W, default 8: word width.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  input  1  requester presents a request.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read; qualified by req_valid.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_W  read data on a read; echo of the written word on a write.
- rsp_was_wr  output  1  response belongs to a write.
- op_count  output  8  completed-operation counter, wraps modulo 256.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid=1, capture req_addr, req_wdata and req_we into internal registers.
  - Next state is WRITE when req_we=1, READ otherwise.
- WRITE:
  - Exactly one word enable is asserted: the one decoded from the captured address.
  - At the end of the cycle, array[addr] <= wdata, rsp_rdata <= wdata and rsp_was_wr <= 1.
  - Next state is RESP.
- READ:
  - At the end of the cycle, rsp_rdata <= array[addr] and rsp_was_wr <= 0.
  - Next state is RESP.
- RESP:
  - rsp_valid = 1, and rsp_rdata and rsp_was_wr are held stable.
  - On rsp_ready=1: next state is IDLE and op_count increments.
  - On rsp_ready=0: stay in RESP indefinitely.
- req_ready is 1 only in IDLE. req_valid outside IDLE is ignored, and the requester must hold the request until it is accepted.
- Word enables are 0 in every state except WRITE. No array word changes outside WRITE.
- Addresses are always in range, because the array depth is exactly 2^ADDR_W.
- rsp_ready outside RESP has no effect.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_was_wr=0, op_count=0, every array word=0.
  - Reset takes effect at the first rising edge with rst_n=0.
  - It overrides any state, including mid-WRITE: the array is cleared and no partial write survives.
- Request accepted at edge N (IDLE with req_valid=1):
  - Cycle N+1: WRITE or READ.
  - From edge N+1: rsp_valid=1.
- With rsp_ready held at 1:
  - The response is consumed at edge N+2.
  - req_ready=1 again from edge N+2.
  - The next request can be accepted at edge N+3.
  - Minimum spacing between accepted requests is 3 cycles.
- A read issued immediately after a write to the same address returns the new data; the array is updated before the READ state samples it.
- op_count wraps from 255 to 0 with no flag.
- rsp_ready is combinationally ignored in every state except RESP. There is no combinational path from any input to any output.

## Test plan
- Reset:
  - Stimulus: rst_n=0 for 2 cycles, then read addresses 0..7.
  - Response: every rsp_rdata=0x00, rsp_was_wr=0, op_count=8 after the 8th response.
- Write then read:
  - Stimulus: write addr 3 = 0xA5, then read addr 3.
  - Response: write response has rsp_rdata=0xA5 and rsp_was_wr=1; read response has rsp_rdata=0xA5; rsp_valid rises exactly 1 cycle after each accept.
- Address isolation:
  - Stimulus: write addr k = 0x10+k for k=0..7, then read all 8.
  - Response: each read returns 0x10+k; no aliasing.
- Response backpressure:
  - Stimulus: read addr 5 (contents 0x3C) with rsp_ready=0 for 4 cycles, pulsing req_valid with a write to addr 5 = 0xFF during the stall.
  - Response: rsp_valid and rsp_rdata=0x3C held for all 4 cycles, req_ready=0, addr 5 still 0x3C afterwards.
- Reset mid-operation:
  - Stimulus: accept a write of 0x77 to addr 2, then assert rst_n=0 during the WRITE cycle.
  - Response: after reset, rsp_valid=0, op_count=0, and a read of addr 2 returns 0x00.
- Counter wrap:
  - Stimulus: 256 back-to-back reads with rsp_ready=1.
  - Response: op_count returns to 0; accepts are spaced exactly 3 cycles apart.
